// File: rtl/dma_pkg.sv
// Shared definitions for the bus_dma word-copy engine.
//   - Register indices as selected by cfg_addr[4:2] (byte offset = index * 4)
//   - CTRL / STATUS bit positions
//   - Copy FSM state encoding
package dma_pkg;

  // Register indices (cfg_addr[4:2]); byte offsets 0x00..0x10.
  localparam logic [2:0] DMA_SRC    = 3'd0;
  localparam logic [2:0] DMA_DST    = 3'd1;
  localparam logic [2:0] DMA_LEN    = 3'd2;
  localparam logic [2:0] DMA_CTRL   = 3'd3;
  localparam logic [2:0] DMA_STATUS = 3'd4;

  // CTRL bits: start is write-1 (reads 0); irq_en exists only with DMA_IRQ_EN.
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  // STATUS bits (read-only).
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RWAIT,
    ST_WR,
    ST_DONE
  } dma_state_e;

endpackage

// File: rtl/bus_dma_regs.sv
// bus_dma_regs: programming registers and cfg read mux of the DMA engine.
// Optional feature macro: DMA_IRQ_EN (CTRL.bit1 irq enable, irq = done & irq_en).
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   cfg_req_i/we_i/addr_i/wdata_i  device-side access; addr[4:2] selects register
//   cfg_rdata_o             read data, registered (valid cycle after request)
//   busy                    engine busy; programming writes are dropped while set
//   done_set                engine is in its DONE cycle
//   src, dst, len           programmed copy parameters
//   start                   one-cycle start strobe (accepted CTRL write with bit0)
//   irq                     done interrupt level
module bus_dma_regs
  import dma_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [31:0]          cfg_addr_i,
  input  logic [DataWidth-1:0] cfg_wdata_i,
  output logic [DataWidth-1:0] cfg_rdata_o,
  input  logic                 busy,
  input  logic                 done_set,
  output logic [31:0]          src,
  output logic [31:0]          dst,
  output logic [LenWidth-1:0]  len,
  output logic                 start,
  output logic                 irq
);

  logic [2:0]           idx;
  logic                 wr_en;
  logic                 ctrl_wr;
  logic                 done;
  logic [DataWidth-1:0] rd_mux;
  logic                 unused_addr;

  assign idx     = cfg_addr_i[4:2];
  assign wr_en   = cfg_req_i & cfg_we_i & ~busy;
  assign ctrl_wr = wr_en & (idx == DMA_CTRL);
  assign start   = ctrl_wr & cfg_wdata_i[CTRL_START];

  // Only bits [4:2] decode the window; the rest alias.
  assign unused_addr = ^{cfg_addr_i[31:5], cfg_addr_i[1:0]};

`ifdef DMA_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      irq_en <= cfg_wdata_i[CTRL_IRQ_EN];
    end
  end

  assign irq = done & irq_en;
`else
  assign irq = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; the reset branch is asynchronous and covers all state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      src <= '0;
      dst <= '0;
      len <= '0;
    end else if (wr_en) begin
      case (idx)
        DMA_SRC: src <= {cfg_wdata_i[31:2], 2'b00};
        DMA_DST: dst <= {cfg_wdata_i[31:2], 2'b00};
        DMA_LEN: len <= cfg_wdata_i[LenWidth-1:0];
        default: ;
      endcase
    end
  end

  // A plain CTRL write landing in the DONE cycle must not lose the completion;
  // a CTRL write carrying start begins a new transfer and clears done.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      done <= 1'b0;
    end else if (done_set && !start) begin
      done <= 1'b1;
    end else if (ctrl_wr) begin
      done <= 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_mux = '0;
    case (idx)
      DMA_SRC:    rd_mux = src;
      DMA_DST:    rd_mux = dst;
      DMA_LEN:    rd_mux[LenWidth-1:0] = len;
`ifdef DMA_IRQ_EN
      DMA_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
`endif
      DMA_STATUS: begin
        rd_mux[STATUS_BUSY] = busy;
        rd_mux[STATUS_DONE] = done;
      end
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cfg_rdata_o <= '0;
    end else if (cfg_req_i && !cfg_we_i) begin
      cfg_rdata_o <= rd_mux;
    end else begin
      cfg_rdata_o <= '0;
    end
  end

endmodule

// File: rtl/bus_dma.sv
// bus_dma: word-copy DMA engine. Programmed through a register window
// (SRC, DST, LEN, CTRL, STATUS), then copies LEN words from SRC to DST as
// read-then-write pairs on its host bus port. Addresses wrap mod 2^32.
// Optional feature macro: DMA_IRQ_EN (done interrupt on irq_o).
// Ports:
//   clk_i, rst_i       clock, asynchronous active-low reset
//   cfg_*              device-side register access (rdata valid next cycle)
//   host_req_o/gnt_i   host request; a transfer happens in a req&gnt cycle
//   host_we_o, host_addr_o, host_wdata_o   held stable until granted
//   host_rdata_i       read data, valid the cycle after a granted read
//   irq_o              done interrupt (0 unless DMA_IRQ_EN)
module bus_dma
  import dma_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [31:0]          cfg_addr_i,
  input  logic [DataWidth-1:0] cfg_wdata_i,
  output logic [DataWidth-1:0] cfg_rdata_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic                 host_we_o,
  output logic [31:0]          host_addr_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic [DataWidth-1:0] host_rdata_i,
  output logic                 irq_o
);

  dma_state_e          state;
  logic [31:0]         src;
  logic [31:0]         dst;
  logic [LenWidth-1:0] len;
  logic                start;
  logic                busy;
  logic                done_set;
  logic [31:0]         cur_src;
  logic [31:0]         cur_dst;
  logic [LenWidth-1:0] remaining;

  assign busy     = (state == ST_RD) || (state == ST_RWAIT) || (state == ST_WR);
  assign done_set = (state == ST_DONE);

  bus_dma_regs #(
    .DataWidth(DataWidth),
    .LenWidth (LenWidth)
  ) u_regs (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cfg_req_i  (cfg_req_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_addr_i (cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i),
    .cfg_rdata_o(cfg_rdata_o),
    .busy       (busy),
    .done_set   (done_set),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .start      (start),
    .irq        (irq_o)
  );

  // host_wdata_o doubles as the data buffer between the read and the write.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      cur_src      <= '0;
      cur_dst      <= '0;
      remaining    <= '0;
      host_req_o   <= 1'b0;
      host_we_o    <= 1'b0;
      host_addr_o  <= '0;
      host_wdata_o <= '0;
    end else begin
      case (state)
        // DONE behaves like IDLE for a new start, so a start written in the
        // DONE cycle restarts immediately.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cur_src   <= src;
            cur_dst   <= dst;
            remaining <= len;
            if (len != '0) begin
              state       <= ST_RD;
              host_req_o  <= 1'b1;
              host_we_o   <= 1'b0;
              host_addr_o <= src;
            end else begin
              state <= ST_DONE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RD: begin
          if (host_gnt_i) begin
            host_req_o <= 1'b0;
            state      <= ST_RWAIT;
          end
        end

        ST_RWAIT: begin
          host_wdata_o <= host_rdata_i;
          host_req_o   <= 1'b1;
          host_we_o    <= 1'b1;
          host_addr_o  <= cur_dst;
          state        <= ST_WR;
        end

        ST_WR: begin
          if (host_gnt_i) begin
            cur_src   <= cur_src + 32'd4;
            cur_dst   <= cur_dst + 32'd4;
            remaining <= remaining - LenWidth'(1);
            host_we_o <= 1'b0;
            if (remaining == LenWidth'(1)) begin
              host_req_o <= 1'b0;
              state      <= ST_DONE;
            end else begin
              // Next read issues straight away; req stays high.
              host_req_o  <= 1'b1;
              host_addr_o <= cur_src + 32'd4;
              state       <= ST_RD;
            end
          end
        end

        default: begin
          host_req_o <= 1'b0;
          host_we_o  <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// Testbench for bus_dma: register-window vector table plus directed copy
// sequences against a small word memory attached to the host port.
module tb_bus_dma;
  import dma_pkg::*;

  localparam logic [31:0] A_SRC    = 32'h00;
  localparam logic [31:0] A_DST    = 32'h04;
  localparam logic [31:0] A_LEN    = 32'h08;
  localparam logic [31:0] A_CTRL   = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;

  logic        clk;
  logic        rst_i;
  logic        cfg_req_i;
  logic        cfg_we_i;
  logic [31:0] cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic [31:0] cfg_rdata_o;
  logic        host_req_o;
  logic        host_gnt_i;
  logic        host_we_o;
  logic [31:0] host_addr_o;
  logic [31:0] host_wdata_o;
  logic [31:0] host_rdata_i;
  logic        irq_o;

  int n_cmp;
  int n_err;

  bus_dma #(.DataWidth(32), .LenWidth(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cfg_req_i   (cfg_req_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_wdata_i (cfg_wdata_i),
    .cfg_rdata_o (cfg_rdata_o),
    .host_req_o  (host_req_o),
    .host_gnt_i  (host_gnt_i),
    .host_we_o   (host_we_o),
    .host_addr_o (host_addr_o),
    .host_wdata_o(host_wdata_o),
    .host_rdata_i(host_rdata_i),
    .irq_o       (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory on the host port, indexed by addr[9:2]; backdoor port for preload.
  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  int          wr_count;
  int          rd_count;
  int          req_cycles;
  logic [31:0] rd_addr [64];

  initial begin
    wr_count   = 0;
    rd_count   = 0;
    req_cycles = 0;
    host_rdata_i = '0;
  end

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    if (host_req_o) req_cycles <= req_cycles + 1;
    if (host_req_o && host_gnt_i) begin
      if (host_we_o) begin
        mem[host_addr_o[9:2]] <= host_wdata_o;
        wr_count <= wr_count + 1;
      end else begin
        host_rdata_i <= mem[host_addr_o[9:2]];
        rd_addr[rd_count[5:0]] <= host_addr_o;
        rd_count <= rd_count + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    bd_we   = 1'b1;
    bd_idx  = addr[9:2];
    bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
    cfg_req_i   = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = addr;
    cfg_wdata_i = data;
    @(negedge clk);
    cfg_req_i = 1'b0;
    cfg_we_i  = 1'b0;
  endtask

  task automatic cfg_read(input logic [31:0] addr, output logic [31:0] data);
    cfg_req_i  = 1'b1;
    cfg_we_i   = 1'b0;
    cfg_addr_i = addr;
    @(negedge clk);
    cfg_req_i = 1'b0;
    data = cfg_rdata_o;
  endtask

  task automatic wait_done(input string name);
    logic [31:0] st;
    int n;
    st = '0;
    n  = 0;
    while (st != 32'h2 && n < 200) begin
      cfg_read(A_STATUS, st);
      n++;
    end
    check(name, st, 32'h2);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int cycles;
    int base_wr;
    int base_rd;
    int base_req;

    n_cmp = 0;
    n_err = 0;
    rst_i = 1'b0;
    cfg_req_i = 1'b0;
    cfg_we_i = 1'b0;
    cfg_addr_i = '0;
    cfg_wdata_i = '0;
    host_gnt_i = 1'b1;
    bd_we = 1'b0;
    bd_idx = '0;
    bd_data = '0;

    vecs[0] = '{"src_align",   A_SRC,    32'h0000_0103, 32'h0000_0100};
    vecs[1] = '{"dst_align",   A_DST,    32'h0000_ABCF, 32'h0000_ABCC};
    vecs[2] = '{"len_trunc",   A_LEN,    32'h0001_2345, 32'h0000_2345};
`ifdef DMA_IRQ_EN
    vecs[3] = '{"ctrl_irqen",  A_CTRL,   32'h0000_0002, 32'h0000_0002};
`else
    vecs[3] = '{"ctrl_irqen",  A_CTRL,   32'h0000_0002, 32'h0000_0000};
`endif
    vecs[4] = '{"ctrl_clear",  A_CTRL,   32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{"status_ro",   A_STATUS, 32'hFFFF_FFFE, 32'h0000_0000};
    vecs[6] = '{"hole_0x14",   32'h14,   32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{"hole_0x1c",   32'h1C,   32'h0000_1234, 32'h0000_0000};

    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_req_we_irq", {29'd0, host_req_o, host_we_o, irq_o}, 32'h0);
    check("rst_host_addr", host_addr_o, 32'h0);
    check("rst_host_wdata", host_wdata_o, 32'h0);
    check("rst_cfg_rdata", cfg_rdata_o, 32'h0);
    cfg_read(A_STATUS, rd);
    check("rst_status", rd, 32'h0);

    // Register window vectors: write, read back.
    for (int i = 0; i < 8; i++) begin
      cfg_write(vecs[i].addr, vecs[i].wdata);
      cfg_read(vecs[i].addr, rd);
      check(vecs[i].name, rd, vecs[i].exp);
    end

    // Four-word copy, grant always high: 3 cycles per word.
    for (int i = 0; i < 4; i++) begin
      poke(32'h100 + 32'(i * 4), 32'hA5A5_0000 + 32'(i * 17 + 3));
      poke(32'h200 + 32'(i * 4), 32'h0);
    end
    cfg_write(A_SRC, 32'h100);
    cfg_write(A_DST, 32'h200);
    cfg_write(A_LEN, 32'd4);
    base_wr = wr_count;
    cfg_write(A_CTRL, 32'h1);
    cycles = 0;
    while ((wr_count - base_wr) < 4 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check("copy4_cycles", cycles, 32'd12);
    @(negedge clk);
    cfg_read(A_STATUS, rd);
    check("copy4_status", rd, 32'h2);
    for (int i = 0; i < 4; i++)
      check($sformatf("copy4_word%0d", i), mem[8'h80 + 8'(i)], 32'hA5A5_0000 + 32'(i * 17 + 3));
    cfg_read(A_SRC, rd);
    check("copy4_src_kept", rd, 32'h100);
`ifndef DMA_IRQ_EN
    check("irq_tied_low", {31'd0, irq_o}, 32'h0);
`endif

    // LEN=0: straight to DONE with no bus traffic; a plain CTRL write in the
    // DONE cycle does not clear the new completion.
    cfg_write(A_CTRL, 32'h0);
    cfg_write(A_LEN, 32'h0);
    base_req = req_cycles;
    cfg_write(A_CTRL, 32'h1);
    cfg_write(A_CTRL, 32'h0);
    cfg_read(A_STATUS, rd);
    check("len0_done_wins", rd, 32'h2);
    check("len0_no_req", req_cycles - base_req, 32'd0);
    cfg_write(A_CTRL, 32'h0);
    cfg_read(A_STATUS, rd);
    check("ctrl_clears_done", rd, 32'h0);

    // Grant withheld for 5 WR cycles: request held stable, single write.
    poke(32'h140, 32'hCAFE_F00D);
    poke(32'h240, 32'h0);
    cfg_write(A_SRC, 32'h140);
    cfg_write(A_DST, 32'h240);
    cfg_write(A_LEN, 32'd1);
    base_wr = wr_count;
    cfg_write(A_CTRL, 32'h1);
    @(negedge clk);
    host_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_req_we", i), {30'd0, host_req_o, host_we_o}, 32'h3);
      check($sformatf("stall%0d_addr", i), host_addr_o, 32'h240);
      check($sformatf("stall%0d_wdata", i), host_wdata_o, 32'hCAFE_F00D);
    end
    check("stall_no_write", wr_count - base_wr, 32'd0);
    host_gnt_i = 1'b1;
    @(negedge clk);
    check("stall_one_write", wr_count - base_wr, 32'd1);
    check("stall_mem", mem[8'h90], 32'hCAFE_F00D);
    wait_done("stall_done");

    // Source address wraps from 0xFFFFFFFC to 0x0.
    poke(32'hFFFF_FFFC, 32'h1111_1111);
    poke(32'h0000_0000, 32'h2222_2222);
    cfg_write(A_SRC, 32'hFFFF_FFFC);
    cfg_write(A_DST, 32'h300);
    cfg_write(A_LEN, 32'd2);
    base_rd = rd_count;
    cfg_write(A_CTRL, 32'h1);
    wait_done("wrap_done");
    check("wrap_nreads", rd_count - base_rd, 32'd2);
    check("wrap_rd0", rd_addr[base_rd[5:0]], 32'hFFFF_FFFC);
    check("wrap_rd1", rd_addr[6'(base_rd + 1)], 32'h0000_0000);
    check("wrap_mem0", mem[8'hC0], 32'h1111_1111);
    check("wrap_mem1", mem[8'hC1], 32'h2222_2222);

`ifdef DMA_IRQ_EN
    // Interrupt: level while done and enabled, drops after CTRL write 0.
    cfg_write(A_SRC, 32'h100);
    cfg_write(A_DST, 32'h3C0);
    cfg_write(A_LEN, 32'd1);
    cfg_write(A_CTRL, 32'h3);
    wait_done("irq_done");
    check("irq_high", {31'd0, irq_o}, 32'h1);
    cfg_write(A_CTRL, 32'h0);
    check("irq_low", {31'd0, irq_o}, 32'h0);
`endif

    // Asynchronous reset in RWAIT aborts at once.
    cfg_write(A_SRC, 32'h100);
    cfg_write(A_DST, 32'h380);
    cfg_write(A_LEN, 32'd3);
    cfg_write(A_CTRL, 32'h1);
    @(negedge clk);
    check("pre_rst_addr", host_addr_o, 32'h100);
    rst_i = 1'b0;
    #1;
    check("rst_async_req", {31'd0, host_req_o}, 32'h0);
    check("rst_async_addr", host_addr_o, 32'h0);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    cfg_read(A_STATUS, rd);
    check("rst_status_after", rd, 32'h0);
    cfg_read(A_LEN, rd);
    check("rst_len_after", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
